// File: rtl/seg7_pkg.sv
// Shared glyph table and code constants for the 7-segment display path.
// Segments are active-low: bit 6 = g ... bit 0 = a.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_P     = 7'h0C;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] CODE_DASH  = 4'd13;
   localparam logic [3:0] CODE_P     = 4'd14;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   function automatic logic [6:0] glyph(input logic [3:0] code);
      case (code)
         4'd0:    glyph = SEG_0;
         4'd1:    glyph = SEG_1;
         4'd2:    glyph = SEG_2;
         4'd3:    glyph = SEG_3;
         4'd4:    glyph = SEG_4;
         4'd5:    glyph = SEG_5;
         4'd6:    glyph = SEG_6;
         4'd7:    glyph = SEG_7;
         4'd8:    glyph = SEG_8;
         4'd9:    glyph = SEG_9;
         4'd10:   glyph = SEG_A;
         4'd11:   glyph = SEG_B;
         4'd12:   glyph = SEG_C;
         4'd13:   glyph = SEG_DASH;
         4'd14:   glyph = SEG_P;
         default: glyph = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph lookup: 4-bit display code to active-low segment pattern.
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = glyph(code);

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed common-anode 7-segment driver with double-buffered frames,
// leading-zero suppression, per-digit blink, decimal points and an anode guard interval.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 2,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_i,
   input  logic                  load_i,
   input  logic [4*N_DIGITS-1:0] digits_i,
   input  logic [N_DIGITS-1:0]   dp_mask_i,
   input  logic [N_DIGITS-1:0]   blink_mask_i,
   input  logic                  lz_blank_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [N_DIGITS-1:0]   an_o,
   output logic                  frame_o
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIV_W-1:0]      div, div_n;
   logic [IDX_W-1:0]      idx, idx_n;
   logic [BLK_W-1:0]      blink_cnt;
   logic                  blink_phase;
   logic                  pending;
   logic [4*N_DIGITS-1:0] act_codes, shd_codes;
   logic [N_DIGITS-1:0]   act_dp, shd_dp;

   logic                  div_last, idx_last, boundary, frame_nxt;
   logic [3:0]            cur_code, rom_code;
   logic                  cur_dp, cur_blink, cur_sup, zero_run, hide;
   logic [N_DIGITS-1:0]   an_lit;
   logic [6:0]            glyph_seg;

   assign div_last = (div == DIV_W'(SCAN_DIV - 1));
   assign idx_last = (idx == IDX_W'(N_DIGITS - 1));
   assign boundary = enable_i && div_last && idx_last;

   always_comb begin
      div_n = div;
      idx_n = idx;
      if (enable_i) begin
         if (div_last) begin
            div_n = '0;
            idx_n = idx_last ? '0 : idx + 1'b1;
         end else begin
            div_n = div + 1'b1;
         end
      end
   end

   // frame_o is looked ahead so it is high during the wrap cycle itself,
   // which is the cycle where a load goes straight into the active buffer.
   assign frame_nxt = enable_i && (div_n == DIV_W'(SCAN_DIV - 1)) &&
                      (idx_n == IDX_W'(N_DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         div         <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         div <= div_n;
         idx <= idx_n;
         if (boundary) begin
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_codes <= {N_DIGITS{CODE_BLANK}};
         shd_codes <= {N_DIGITS{CODE_BLANK}};
         act_dp    <= '0;
         shd_dp    <= '0;
         pending   <= 1'b0;
      end else if (boundary) begin
         pending <= 1'b0;
         if (load_i) begin
            act_codes <= digits_i;
            act_dp    <= dp_mask_i;
            shd_codes <= digits_i;
            shd_dp    <= dp_mask_i;
         end else if (pending) begin
            act_codes <= shd_codes;
            act_dp    <= shd_dp;
         end
      end else if (load_i) begin
         shd_codes <= digits_i;
         shd_dp    <= dp_mask_i;
         pending   <= 1'b1;
      end
   end

   // Walk from the most significant digit down so zero_run tells whether
   // this digit and everything to its left are zero.
   always_comb begin
      cur_code  = CODE_BLANK;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_sup   = 1'b0;
      zero_run  = 1'b1;
      an_lit    = '1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_run  = zero_run && (act_codes[4*k +: 4] == 4'd0);
         an_lit[k] = (idx != IDX_W'(k));
         if (idx == IDX_W'(k)) begin
            cur_code  = act_codes[4*k +: 4];
            cur_dp    = act_dp[k];
            cur_blink = blink_mask_i[k];
            cur_sup   = lz_blank_i && (k != 0) && zero_run;
         end
      end
   end

   assign hide     = blink_phase && cur_blink;
   assign rom_code = (cur_sup || hide) ? CODE_BLANK : cur_code;

   seg7_glyph_rom u_rom (
      .code (rom_code),
      .seg  (glyph_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_o   <= SEG_BLANK;
         dp_o    <= 1'b1;
         an_o    <= '1;
         frame_o <= 1'b0;
      end else begin
         frame_o <= frame_nxt;
         if (!enable_i || (div < DIV_W'(GUARD))) begin
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
            an_o  <= '1;
         end else begin
            seg_o <= glyph_seg;
            dp_o  <= hide ? 1'b1 : ~cur_dp;
            an_o  <= an_lit;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-digit, 4-cycle-slot, 1-cycle-guard
// configuration; each frame is checked cycle by cycle against hand-computed glyphs.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_i;
   logic        load_i;
   logic [15:0] digits_i;
   logic [3:0]  dp_mask_i;
   logic [3:0]  blink_mask_i;
   logic        lz_blank_i;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;
   logic        frame_o;

   int checks   = 0;
   int failures = 0;

   seg7_scan_driver #(
      .N_DIGITS     (4),
      .SCAN_DIV     (4),
      .GUARD        (1),
      .BLINK_FRAMES (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .load_i       (load_i),
      .digits_i     (digits_i),
      .dp_mask_i    (dp_mask_i),
      .blink_mask_i (blink_mask_i),
      .lz_blank_i   (lz_blank_i),
      .seg_o        (seg_o),
      .dp_o         (dp_o),
      .an_o         (an_o),
      .frame_o      (frame_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] ea, input logic [6:0] es,
                            input logic edp, input logic ef);
      checks++;
      assert ({an_o, seg_o, dp_o, frame_o} === {ea, es, edp, ef}) else begin
         failures++;
         $error("FAIL %s: got an=%h seg=%h dp=%b frame=%b, want an=%h seg=%h dp=%b frame=%b",
                tag, an_o, seg_o, dp_o, frame_o, ea, es, edp, ef);
      end
   endtask

   task automatic check_frame_bit(input string tag, input logic ef);
      checks++;
      assert (frame_o === ef) else begin
         failures++;
         $error("FAIL %s: got frame=%b want frame=%b", tag, frame_o, ef);
      end
   endtask

   task automatic wait_frame(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (frame_o === 1'b1) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         failures++;
         $error("FAIL %s: frame_o got 0 for 40 cycles, want a 1", tag);
      end
   endtask

   // Entered in the wrap cycle (frame_o high); returns in the next wrap cycle.
   // ld_at = edges already taken before driving a one-cycle load (-1 = none).
   task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpo,
                              input int ld_at, input logic [15:0] ld_d, input logic [3:0] ld_dp);
      logic [6:0] es[4];
      logic [3:0] ea;
      int j;
      int d;
      es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
      for (int k = 1; k <= 16; k++) begin
         if (ld_at == k - 1) begin
            digits_i  = ld_d;
            dp_mask_i = ld_dp;
            load_i    = 1'b1;
         end
         tick();
         load_i = 1'b0;
         if (k == 1) begin
            check_frame_bit($sformatf("%s_k1", name), 1'b0);
         end else begin
            j  = k - 2;
            d  = j / 4;
            ea = 4'hF;
            if (j % 4 == 0) begin
               check_out($sformatf("%s_guard_d%0d", name, d), 4'hF, 7'h7F, 1'b1, k == 16);
            end else begin
               ea[d] = 1'b0;
               check_out($sformatf("%s_d%0d_c%0d", name, d, j % 4), ea, es[d], dpo[d], k == 16);
            end
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      enable_i     = 1'b0;
      load_i       = 1'b0;
      digits_i     = 16'h0000;
      dp_mask_i    = 4'h0;
      blink_mask_i = 4'h0;
      lz_blank_i   = 1'b0;
      tick();
      tick();
      check_out("reset", 4'hF, 7'h7F, 1'b1, 1'b0);

      rst      = 1'b0;
      enable_i = 1'b1;
      tick(); tick(); tick();
      digits_i  = 16'h1234;
      dp_mask_i = 4'h0;
      load_i    = 1'b1;
      tick();
      load_i = 1'b0;
      wait_frame("first_frame");

      // frame 1: 1234 now active
      check_frame("f1_1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, -1, 16'h0, 4'h0);
      // frame 2: mid-frame load must not disturb the frame on screen
      check_frame("f2_midload", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 6, 16'h00F5, 4'b0100);
      check_frame("f3_00f5", 7'h12, 7'h7F, 7'h40, 7'h40, 4'b1011, -1, 16'h0, 4'h0);

      lz_blank_i = 1'b1;
      check_frame("f4_lz0007", 7'h78, 7'h7F, 7'h7F, 7'h7F, 4'b1101, 0, 16'h0007, 4'b0010);
      check_frame("f5_lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF, 0, 16'h0000, 4'h0);

      lz_blank_i   = 1'b0;
      blink_mask_i = 4'b0001;
      check_frame("f6_blink_off", 7'h7F, 7'h30, 7'h24, 7'h79, 4'hF, 0, 16'h1234, 4'b0001);
      check_frame("f7_blink_off", 7'h7F, 7'h30, 7'h24, 7'h79, 4'hF, -1, 16'h0, 4'h0);
      check_frame("f8_blink_on", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1110, -1, 16'h0, 4'h0);

      blink_mask_i = 4'b0000;
      check_frame("f9_edca", 7'h08, 7'h46, 7'h3F, 7'h0C, 4'hF, 0, 16'hEDCA, 4'h0);

      enable_i = 1'b0;
      tick();
      check_out("disable_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
      tick();
      tick();
      check_out("disable_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
      enable_i = 1'b1;
      check_frame("f10_reenable", 7'h08, 7'h46, 7'h3F, 7'h0C, 4'hF, -1, 16'h0, 4'h0);

      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      check_out("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0;
      wait_frame("post_reset_frame");
      check_frame("post_reset_blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, -1, 16'h0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
